// File: rtl/ram_bus_pkg.sv
// Shared definitions for the single-port RAM bus: FSM encoding, default bus
// widths used by the RAM wrappers, and the read-latency counter width.
package ram_bus_pkg;

  localparam int ADDR_WIDTH_DEF = 28;
  localparam int DATA_WIDTH_DEF = 16;
  // Three bits cover read latencies up to 7.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_bus_master.sv
// RAM bus initiator: turns a valid/ready request stream into RAM write/read
// bus cycles and returns read data on a valid/ready response port.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [1:0]            dbg_state
);

  // Handshakes: a request transfers at a posedge with req_valid && req_ready;
  // a response transfers at a posedge with rsp_valid && rsp_ready. Payloads
  // are held stable by their source until the transfer edge.

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_cs;
  logic                  r_we;
  logic                  r_oe;
  logic                  r_drive;
  logic                  r_rsp_valid;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_accept;
  logic                  w_cnt_zero;

  assign req_ready  = rst_n && (r_state == ST_IDLE);
  assign w_accept   = req_valid && req_ready;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = req_we ? ST_WRITE : ST_READ;
      ST_WRITE: w_next = ST_IDLE;
      ST_READ:  if (w_cnt_zero) w_next = ST_RESP;
      ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Bus controls are registered on the transition into each state so the
  // RAM never sees a combinational path from the request or response ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_oe        <= 1'b0;
      r_drive     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cs    <= 1'b1;
            r_we    <= req_we;
            r_oe    <= !req_we;
            r_drive <= req_we;
            r_cnt   <= req_we ? '0 : CNT_W'(READ_LATENCY);
          end
        end
        ST_WRITE: begin
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_drive <= 1'b0;
        end
        ST_READ: begin
          if (w_cnt_zero) begin
            r_rdata     <= mem_data;
            r_rsp_valid <= 1'b1;
            r_cs        <= 1'b0;
            r_oe        <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_data  = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
  assign mem_addr  = r_addr;
  assign mem_cs    = r_cs;
  assign mem_we    = r_we;
  assign mem_oe    = r_oe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign dbg_state = r_state;

endmodule
